// File: rtl/hex_disp_scan_ctrl.sv
// Scan controller for N_DIG common-anode 7-segment digits: one digit per slot, anti-ghost blank window,
// host updates staged in shadow regs and committed only at frame boundaries. Outputs registered, 1-cycle latency.
module hex_disp_scan_ctrl #(
  parameter int N_DIG     = 8,
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               wr,
  input  logic [4*N_DIG-1:0] hex_in,
  input  logic [N_DIG-1:0]   dp_in,
  input  logic [N_DIG-1:0]   blank_in,
  output logic [N_DIG-1:0]   an,
  output logic [7:0]         sseg,
  output logic               upd_pend,
  output logic               frame_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [CW-1:0]    CNT_MAX   = CW'(DIV - 1);
  localparam logic [CW-1:0]    BLANK_LIM = CW'(BLANK_CYC);
  localparam logic [IW-1:0]    IDX_MAX   = IW'(N_DIG - 1);
  localparam logic [N_DIG-1:0] AN_ONE    = {{(N_DIG-1){1'b0}}, 1'b1};

  function automatic logic [6:0] seg7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [4*N_DIG-1:0] hex_sh_q, hex_sh_d, hex_act_q, hex_act_d;
  logic [N_DIG-1:0]   dp_sh_q, dp_sh_d, dp_act_q, dp_act_d;
  logic [N_DIG-1:0]   blank_sh_q, blank_sh_d, blank_act_q, blank_act_d;
  logic               pend_q, pend_d;
  logic               tick_q, tick_d;
  logic [N_DIG-1:0]   an_q, an_d;
  logic [7:0]         sseg_q, sseg_d;

  logic last_cnt, last_idx, frame_bnd, in_blank, dark;
  logic [3:0] cur_nib;

  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    hex_sh_d    = hex_sh_q;
    dp_sh_d     = dp_sh_q;
    blank_sh_d  = blank_sh_q;
    hex_act_d   = hex_act_q;
    dp_act_d    = dp_act_q;
    blank_act_d = blank_act_q;
    pend_d      = pend_q;

    last_cnt  = (cnt_q == CNT_MAX);
    last_idx  = (idx_q == IDX_MAX);
    frame_bnd = en && last_cnt && last_idx;
    tick_d    = frame_bnd;

    if (en) begin
      if (last_cnt) begin
        cnt_d = '0;
        idx_d = last_idx ? '0 : idx_q + IW'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (wr) begin
      hex_sh_d   = hex_in;
      dp_sh_d    = dp_in;
      blank_sh_d = blank_in;
    end

    // A write landing on the boundary bypasses the shadow so it shows from the very next frame.
    if (frame_bnd && wr) begin
      hex_act_d   = hex_in;
      dp_act_d    = dp_in;
      blank_act_d = blank_in;
      pend_d      = 1'b0;
    end else if (frame_bnd && pend_q) begin
      hex_act_d   = hex_sh_q;
      dp_act_d    = dp_sh_q;
      blank_act_d = blank_sh_q;
      pend_d      = 1'b0;
    end else if (wr) begin
      pend_d = 1'b1;
    end

    in_blank = (BLANK_CYC != 0) && (cnt_q < BLANK_LIM);
    dark     = !en || in_blank || blank_act_q[idx_q];
    cur_nib  = hex_act_q[{idx_q, 2'b00} +: 4];

    an_d   = '1;
    sseg_d = 8'hFF;
    if (!dark) begin
      an_d   = ~(AN_ONE << idx_q);
      sseg_d = {~dp_act_q[idx_q], seg7(cur_nib)};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      hex_sh_q    <= '0;
      dp_sh_q     <= '0;
      blank_sh_q  <= '0;
      hex_act_q   <= '0;
      dp_act_q    <= '0;
      blank_act_q <= '0;
      pend_q      <= 1'b0;
      tick_q      <= 1'b0;
      an_q        <= '1;
      sseg_q      <= 8'hFF;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      hex_sh_q    <= hex_sh_d;
      dp_sh_q     <= dp_sh_d;
      blank_sh_q  <= blank_sh_d;
      hex_act_q   <= hex_act_d;
      dp_act_q    <= dp_act_d;
      blank_act_q <= blank_act_d;
      pend_q      <= pend_d;
      tick_q      <= tick_d;
      an_q        <= an_d;
      sseg_q      <= sseg_d;
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign upd_pend   = pend_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_hex_disp_scan_ctrl.sv
// Directed bench for hex_disp_scan_ctrl (N_DIG=4, DIV=4, BLANK_CYC=1) with a cycle scoreboard.
module tb_hex_disp_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        wr;
  logic [15:0] hex_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        upd_pend;
  logic        frame_tick;

  int n_chk  = 0;
  int n_fail = 0;

  hex_disp_scan_ctrl #(.N_DIG(4), .DIV(4), .BLANK_CYC(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .wr         (wr),
    .hex_in     (hex_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .an         (an),
    .sseg       (sseg),
    .upd_pend   (upd_pend),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Scoreboard: a behavioural model pushes the expected outputs at every edge, checker pops on the falling edge.
  typedef struct packed {
    logic [3:0] an;
    logic [7:0] sseg;
    logic       pend;
    logic       tick;
  } exp_t;

  exp_t        sb_q[$];
  logic [1:0]  m_cnt, m_idx;
  logic [15:0] m_hex_a, m_hex_s;
  logic [3:0]  m_dp_a, m_dp_s, m_bl_a, m_bl_s;
  logic        m_pend;

  always @(posedge clk or negedge reset) begin
    exp_t e;
    logic dark, bnd;
    if (!reset) begin
      m_cnt = 0; m_idx = 0; m_pend = 0;
      m_hex_a = 0; m_hex_s = 0; m_dp_a = 0; m_dp_s = 0; m_bl_a = 0; m_bl_s = 0;
      sb_q.delete();
    end else begin
      dark   = !en || (m_cnt == 0) || m_bl_a[m_idx];
      bnd    = en && (m_cnt == 3) && (m_idx == 3);
      e.an   = dark ? 4'hF : ~(4'b0001 << m_idx);
      e.sseg = dark ? 8'hFF : {~m_dp_a[m_idx], seg7(m_hex_a[4*m_idx +: 4])};
      e.tick = bnd;
      if (bnd && wr) begin
        m_hex_a = hex_in; m_dp_a = dp_in; m_bl_a = blank_in; m_pend = 0;
      end else if (bnd && m_pend) begin
        m_hex_a = m_hex_s; m_dp_a = m_dp_s; m_bl_a = m_bl_s; m_pend = 0;
      end else if (wr) begin
        m_pend = 1;
      end
      if (wr) begin
        m_hex_s = hex_in; m_dp_s = dp_in; m_bl_s = blank_in;
      end
      e.pend = m_pend;
      sb_q.push_back(e);
      if (en) begin
        if (m_cnt == 3) begin
          m_cnt = 0;
          m_idx = m_idx + 2'd1;
        end else begin
          m_cnt = m_cnt + 2'd1;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("sb_an",   32'(an),         32'(e.an));
      chk("sb_sseg", 32'(sseg),       32'(e.sseg));
      chk("sb_pend", 32'(upd_pend),   32'(e.pend));
      chk("sb_tick", 32'(frame_tick), 32'(e.tick));
    end
  end

  task automatic wait_state(input logic [1:0] i, input logic [1:0] c);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (m_idx == i && m_cnt == c) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("wait_state_timeout", 32'(found), 32'd1);
  endtask

  // Waits for the frame_tick sample; optionally checks lit digits hold a value and update stays pending.
  task automatic wait_tick(input logic hold_chk, input logic [7:0] hold_seg);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (frame_tick) begin
        found = 1'b1;
        break;
      end
      if (hold_chk) begin
        chk("hold_pend", 32'(upd_pend), 32'd1);
        if (an != 4'hF) chk("hold_seg", 32'(sseg), 32'(hold_seg));
      end
    end
    chk("wait_tick_timeout", 32'(found), 32'd1);
  endtask

  // Checks the 16 samples of a full frame; call when the next sample is idx 0, cnt 0.
  task automatic check_frame(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                             input logic [7:0] e3, input logic [3:0] bl);
    logic [7:0] es;
    logic [3:0] ea;
    logic       dark;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      case (j / 4)
        0: es = e0;
        1: es = e1;
        2: es = e2;
        default: es = e3;
      endcase
      dark = (j % 4 == 0) || bl[j / 4];
      ea   = dark ? 4'hF : ~(4'b0001 << (j / 4));
      chk("frm_an",   32'(an),         32'(ea));
      chk("frm_sseg", 32'(sseg),       dark ? 32'hFF : 32'(es));
      chk("frm_tick", 32'(frame_tick), (j == 15) ? 32'd1 : 32'd0);
      chk("frm_pend", 32'(upd_pend),   32'd0);
    end
  endtask

  initial begin
    logic [63:0] an_seq;
    logic [3:0]  ea;
    int          ticks;
    an_seq   = 64'hFEEE_FDDD_FBBB_F777;
    reset    = 1'b0;
    en       = 1'b1;
    wr       = 1'b0;
    hex_in   = '0;
    dp_in    = '0;
    blank_in = '0;

    repeat (3) @(negedge clk);
    chk("rst_an",   32'(an),         32'hF);
    chk("rst_sseg", 32'(sseg),       32'hFF);
    chk("rst_pend", 32'(upd_pend),   32'd0);
    chk("rst_tick", 32'(frame_tick), 32'd0);
    reset = 1'b1;

    // Plain scan after reset: anode sequence, digit-0 glyph, one tick per 16 cycles.
    ticks = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      ea = an_seq[63 - 4*(k % 16) -: 4];
      chk("scan_an",   32'(an),   32'(ea));
      chk("scan_sseg", 32'(sseg), (ea == 4'hF) ? 32'hFF : 32'hC0);
      if (frame_tick) ticks++;
    end
    chk("scan_ticks", 32'(ticks), 32'd2);

    // Mid-frame write stays pending until the boundary.
    wait_state(2'd1, 2'd2);
    hex_in = 16'hF3A0;
    wr     = 1'b1;
    @(negedge clk);
    wr     = 1'b0;
    hex_in = 16'h0000;
    chk("mid_pend", 32'(upd_pend), 32'd1);
    wait_tick(1'b1, 8'hC0);
    chk("mid_pend_clr", 32'(upd_pend), 32'd0);
    check_frame(8'hC0, 8'h88, 8'hB0, 8'h8E, 4'b0000);

    // Write on the boundary cycle goes straight to active.
    wait_state(2'd3, 2'd3);
    hex_in = 16'h1234;
    wr     = 1'b1;
    @(negedge clk);
    wr     = 1'b0;
    hex_in = 16'h0000;
    chk("bnd_tick", 32'(frame_tick), 32'd1);
    chk("bnd_pend", 32'(upd_pend),   32'd0);
    check_frame(8'h99, 8'hB0, 8'hA4, 8'hF9, 4'b0000);

    // Decimal point on digit 1, digit 2 blanked.
    wait_state(2'd0, 2'd2);
    hex_in   = 16'h1234;
    dp_in    = 4'b0010;
    blank_in = 4'b0100;
    wr       = 1'b1;
    @(negedge clk);
    wr       = 1'b0;
    hex_in   = 16'h0000;
    dp_in    = 4'b0000;
    blank_in = 4'b0000;
    wait_tick(1'b0, 8'h00);
    check_frame(8'h99, 8'h30, 8'hA4, 8'hF9, 4'b0100);

    wait_state(2'd0, 2'd2);
    hex_in = 16'h1234;
    wr     = 1'b1;
    @(negedge clk);
    wr     = 1'b0;
    hex_in = 16'h0000;
    wait_tick(1'b0, 8'h00);
    check_frame(8'h99, 8'hB0, 8'hA4, 8'hF9, 4'b0000);

    // Scan pause at idx 2, cnt 2, then resume from the same place.
    wait_state(2'd2, 2'd2);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("pause_an",   32'(an),         32'hF);
      chk("pause_sseg", 32'(sseg),       32'hFF);
      chk("pause_tick", 32'(frame_tick), 32'd0);
    end
    en = 1'b1;
    @(negedge clk);
    chk("resume_an0",   32'(an),   32'hB);
    chk("resume_sseg0", 32'(sseg), 32'hA4);
    @(negedge clk);
    chk("resume_an1",   32'(an),   32'hB);
    @(negedge clk);
    chk("resume_an2",   32'(an),   32'hF);
    @(negedge clk);
    chk("resume_an3",   32'(an),   32'h7);
    chk("resume_sseg3", 32'(sseg), 32'hF9);

    // Asynchronous reset mid-slot with an update pending.
    wait_state(2'd1, 2'd1);
    hex_in = 16'h5555;
    wr     = 1'b1;
    @(negedge clk);
    wr     = 1'b0;
    hex_in = 16'h0000;
    chk("pre_rst_pend", 32'(upd_pend), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_an",   32'(an),         32'hF);
    chk("arst_sseg", 32'(sseg),       32'hFF);
    chk("arst_pend", 32'(upd_pend),   32'd0);
    chk("arst_tick", 32'(frame_tick), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_disp_scan_ctrl.md
Name: hex_disp_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of common-anode 7-segment digits. It holds N_DIG hex nibbles plus decimal-point and blank masks in shadow/active register pairs. It steps one digit per slot, decodes the selected nibble to active-low segments, and drives one anode at a time. Each slot opens with an anti-ghosting blank window. Host updates are tear-free: they are committed only at frame boundaries. The block sits between the MMIO display core and the board segment/anode pins.

Parameters:
N_DIG, 8, number of digits scanned (2..16).
DIV, 50000, clock cycles per digit slot (DIV >= 2).
BLANK_CYC, 8, cycles at the start of each slot with all anodes off (0 <= BLANK_CYC < DIV).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-low (asserted when 0)
en  in  1  scan enable
wr  in  1  single-cycle update strobe
hex_in  in  4*N_DIG  nibble k at bits [4k+3:4k]
dp_in  in  N_DIG  decimal point k on (active-high)
blank_in  in  N_DIG  digit k forced dark (active-high)
an  out  N_DIG  anode enables, active-low, one-hot-zero
sseg  out  8  {dp, g..a}, active-low
upd_pend  out  1  shadow holds data not yet committed
frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (reset=0, async): cnt=0, idx=0, active and shadow regs=0, upd_pend=0, frame_tick=0, an=all 1, sseg=8'hFF. Reset mid-frame aborts the scan immediately; the first slot after release is idx 0.
- Prescaler cnt runs 0..DIV-1 while en=1. At cnt==DIV-1: cnt wraps to 0 and idx advances, with N_DIG-1 wrapping to 0.
- Frame boundary: cnt==DIV-1 && idx==N_DIG-1 && en=1. frame_tick=1 on the next cycle only.
- en=0: cnt and idx hold, an=all 1 and sseg=8'hFF on the next cycle, no frame_tick. Scanning resumes from the held state.
- Outputs are registered, with one cycle latency from the (cnt, idx) state:
  - cnt < BLANK_CYC, or blank_act[idx]=1: an=all 1, sseg=8'hFF.
  - Otherwise: an = ~(1<<idx), sseg = {~dp_act[idx], seg(hex_act[idx])}.
- seg() table, 7-bit gfedcba, active-low: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 B=03 C=46 D=21 E=06 F=0E.
- Update handshake:
  - wr=1 captures hex_in/dp_in/blank_in into the shadow regs and sets upd_pend=1 the next cycle. A later wr before commit overwrites the shadow (last write wins).
  - At a frame boundary with upd_pend=1, shadow is copied to active and upd_pend clears. The display changes only from the slot starting at idx 0.
  - wr in the same cycle as a frame boundary: the new inputs load both shadow and active directly and upd_pend=0.
  - Frame boundary with upd_pend=0: active is unchanged.
- Active regs never change except at reset or a frame boundary.
- At most one an bit is low in any cycle, including on transitions.

Test Plan:
1. Reset release, N_DIG=4, DIV=4, BLANK_CYC=1, en=1. The an sequence (per cycle, after one-cycle latency) is F,E,E,E,F,D,D,D,F,B,B,B,F,7,7,7, repeating. frame_tick pulses once every 16 cycles, and sseg=40 (digit 0) during lit cycles.
2. wr with hex_in=16'hF3A0 mid-frame: upd_pend=1 until the boundary. Lit sseg stays 40 until then. From the next idx-0 slot, digits 0..3 show 40, 08, 30, 0E, and upd_pend=0.
3. wr on the exact frame-boundary cycle: new data appears from the very next idx-0 slot, and upd_pend never rises.
4. dp_in=4'b0010, blank_in=4'b0100 committed: digit 1 sseg bit7=0, and digit 2 slot has an=all 1 for the whole slot.
5. en dropped for 10 cycles at idx=2, cnt=2: outputs are dark the next cycle, no frame_tick. After re-enable, the scan continues at idx 2, cnt 2.
6. reset asserted asynchronously mid-slot with upd_pend=1: outputs go dark immediately, and upd_pend and active regs are 0. After release, all lit digits show 40.
